nec_ir_rx: RTL
==============

Name: nec_ir_rx

Overview:
- Parametrised NEC infrared frame receiver. Next generation of the team's fixed 0.5625 ms-sample IR decoder.
- Measures mark/space durations on a fine tick grid and validates every pulse against a tolerance window.
- Decodes 32-bit NEC frames (LSB first), including repeat codes, and reports errors and timeouts.
- Sits between the demodulating IR receiver pin and the UI/control logic.

Parameters:
- TICK_DIV, 2812: clk cycles per duration tick (56.25 us at 50 MHz); must be >= 2.
- ACTIVE_LOW, 1: 1 = ir_in low means carrier present (mark); 0 = high means mark.
- CHECK_ADDR, 1: 1 = require address byte1 == ~byte0, address = {8'h00, byte0}; 0 = extended NEC, address = {byte1, byte0}.
- REPEAT_EN, 1: 1 = decode repeat codes; 0 = treat a repeat leader as an error.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ir_in  input  1  raw demodulated IR pin, asynchronous to clk
- address  output  16  address of last valid frame
- command  output  8  command of last valid frame
- frame_valid  output  1  one-cycle pulse when address/command update
- repeat_pulse  output  1  one-cycle pulse on a valid repeat code
- err  output  1  one-cycle pulse on any timing, timeout or checksum failure
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async): all outputs 0; FSM to IDLE; shift register, bit count and have_frame flag cleared. Reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-FF synchroniser, then an edge register; the mark level is normalised by ACTIVE_LOW.
  - mark_start and mark_end are single-cycle events.
- Duration measurement:
  - Each edge event clears the prescaler and the 8-bit dur counter.
  - dur increments once per TICK_DIV clk cycles and saturates at 255.
- Windows (ticks, inclusive):
  - LEAD_M 144..176
  - LEAD_S 72..88
  - RPT_S 36..44
  - BIT_M 7..13
  - ZERO_S 7..13
  - ONE_S 26..34
- States: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK.
  - IDLE: mark_start -> LEAD_MARK. All other activity is ignored, including a pin already in mark after an error.
  - LEAD_MARK: mark_end with dur in LEAD_M -> LEAD_SPACE; otherwise err -> IDLE. dur exceeding 176 while in mark -> err -> IDLE immediately.
  - LEAD_SPACE: on mark_start:
    - dur in LEAD_S -> BIT_MARK, bitcnt = 0.
    - dur in RPT_S and REPEAT_EN -> RPT_MARK.
    - Otherwise err -> IDLE.
    - Timeout when dur exceeds 88.
  - BIT_MARK: on mark_end with dur in BIT_M:
    - bitcnt == 32 -> frame check, then IDLE.
    - Otherwise -> BIT_SPACE.
    - Out of window -> err -> IDLE. Timeout when dur exceeds 13.
  - BIT_SPACE: on mark_start:
    - dur in ZERO_S shifts in 0; dur in ONE_S shifts in 1; either way bitcnt++ and -> BIT_MARK.
    - Otherwise err -> IDLE. Timeout when dur exceeds 34.
  - RPT_MARK: mark_end with dur in BIT_M -> repeat_pulse only if have_frame, then IDLE. Out of window -> err -> IDLE.
- Shifting: 32-bit shift register shifts right, new bit enters bit 31. After 32 bits: byte0 = [7:0], byte1 = [15:8], byte2 = [23:16], byte3 = [31:24].
- Frame check:
  - Pass requires byte3 == ~byte2, and byte1 == ~byte0 when CHECK_ADDR = 1.
  - Pass: address and command load, frame_valid pulses, have_frame is set.
  - Fail: err pulses; address and command are held.
- Output latency: frame_valid, repeat_pulse and err (edge-triggered cases) assert exactly 4 clk cycles after the causing ir_in transition. Timeout err asserts 1 cycle after dur passes the window maximum.
- At most one of frame_valid, repeat_pulse and err is high in any cycle.
- address and command hold their value until the next valid frame or reset.
- busy is registered from the FSM state.

Test Plan:
- Valid frame, addr 0x59 / cmd 0x16, nominal timing at TICK_DIV = 2812 -> address = 0x0059, command = 0x16; frame_valid high exactly 1 cycle, 4 clk after the stop-mark end; err stays 0.
- Same frame, then a repeat code 40 ms later -> repeat_pulse for 1 cycle; address/command unchanged. A repeat code right after reset -> no repeat_pulse, no err.
- Cmd inverse byte corrupted (byte3 = 0xE8 with byte2 = 0x16) -> err for 1 cycle; outputs hold their previous values; busy returns to 0.
- Leader mark of 7 ms (124 ticks) -> err at the mark end. Space stuck for 3 ms after bit 5 -> err when dur reaches 35; FSM returns to IDLE.
- CHECK_ADDR = 0, bytes 0x34, 0x12, 0x40, 0xBF -> address = 0x1234, command = 0x40, frame_valid pulses once.
- Reset asserted after 10 bits -> all outputs 0 asynchronously; the following full frame (addr 0x00, cmd 0x45) decodes correctly.

Source files
------------

// File: rtl/nec_ir_rx.sv
// NEC infrared frame receiver: synchronises the demodulated pin, times marks/spaces
// on a tick grid and decodes 32-bit frames and repeat codes with tolerance windows.
module nec_ir_rx #(
  parameter int TICK_DIV   = 2812,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit CHECK_ADDR = 1'b1,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_in,
  output logic [15:0] address,
  output logic [7:0]  command,
  output logic        frame_valid,
  output logic        repeat_pulse,
  output logic        err,
  output logic        busy
);

  // state      | meaning
  // IDLE       | waiting for a leader mark
  // LEAD_MARK  | timing the 9 ms leader mark
  // LEAD_SPACE | timing the leader space (frame or repeat)
  // BIT_MARK   | timing a 562 us bit/stop mark
  // BIT_SPACE  | timing a data space, decides 0/1
  // RPT_MARK   | timing the repeat-code stop mark
  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, RPT_MARK
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LOAD = PW'(TICK_DIV - 1);

  state_t        state;
  logic          ir_s1, ir_s2, mark_q;
  logic          mark_n, mark_start, mark_end;
  logic [PW-1:0] presc;
  logic [7:0]    dur;
  logic [31:0]   sr;
  logic [5:0]    bitcnt;
  logic          have_frame;

  assign mark_n = ACTIVE_LOW ? ~ir_s2 : ir_s2;

  // Synchroniser resets to the idle (no-carrier) level so release never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_s1      <= ACTIVE_LOW;
      ir_s2      <= ACTIVE_LOW;
      mark_q     <= 1'b0;
      mark_start <= 1'b0;
      mark_end   <= 1'b0;
    end else begin
      ir_s1      <= ir_in;
      ir_s2      <= ir_s1;
      mark_q     <= mark_n;
      mark_start <= mark_n & ~mark_q;
      mark_end   <= ~mark_n & mark_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= PRESC_LOAD;
      dur   <= 8'd0;
    end else if (mark_start || mark_end) begin
      presc <= PRESC_LOAD;
      dur   <= 8'd0;
    end else if (presc == '0) begin
      presc <= PRESC_LOAD;
      if (dur != 8'hFF) dur <= dur + 8'd1;
    end else begin
      presc <= presc - 1'b1;
    end
  end

  function automatic logic in_win(input logic [7:0] d, input logic [7:0] lo, input logic [7:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  logic frame_ok;
  assign frame_ok = (sr[31:24] == ~sr[23:16]) && (!CHECK_ADDR || (sr[15:8] == ~sr[7:0]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      address      <= 16'h0000;
      command      <= 8'h00;
      frame_valid  <= 1'b0;
      repeat_pulse <= 1'b0;
      err          <= 1'b0;
      sr           <= 32'h0;
      bitcnt       <= 6'd0;
      have_frame   <= 1'b0;
    end else begin
      frame_valid  <= 1'b0;
      repeat_pulse <= 1'b0;
      err          <= 1'b0;
      case (state)
        IDLE:
          if (mark_start) state <= LEAD_MARK;
        LEAD_MARK:
          if (mark_end) begin
            if (in_win(dur, 8'd144, 8'd176)) state <= LEAD_SPACE;
            else begin err <= 1'b1; state <= IDLE; end
          end else if (dur > 8'd176) begin
            err <= 1'b1; state <= IDLE;
          end
        LEAD_SPACE:
          if (mark_start) begin
            if (in_win(dur, 8'd72, 8'd88)) begin
              bitcnt <= 6'd0;
              state  <= BIT_MARK;
            end else if (REPEAT_EN && in_win(dur, 8'd36, 8'd44)) begin
              state <= RPT_MARK;
            end else begin
              err <= 1'b1; state <= IDLE;
            end
          end else if (dur > 8'd88) begin
            err <= 1'b1; state <= IDLE;
          end
        BIT_MARK:
          if (mark_end) begin
            if (!in_win(dur, 8'd7, 8'd13)) begin
              err <= 1'b1; state <= IDLE;
            end else if (bitcnt == 6'd32) begin
              state <= IDLE;
              if (frame_ok) begin
                address     <= CHECK_ADDR ? {8'h00, sr[7:0]} : sr[15:0];
                command     <= sr[23:16];
                frame_valid <= 1'b1;
                have_frame  <= 1'b1;
              end else begin
                err <= 1'b1;
              end
            end else begin
              state <= BIT_SPACE;
            end
          end else if (dur > 8'd13) begin
            err <= 1'b1; state <= IDLE;
          end
        BIT_SPACE:
          if (mark_start) begin
            if (in_win(dur, 8'd7, 8'd13) || in_win(dur, 8'd26, 8'd34)) begin
              sr     <= {in_win(dur, 8'd26, 8'd34), sr[31:1]};
              bitcnt <= bitcnt + 6'd1;
              state  <= BIT_MARK;
            end else begin
              err <= 1'b1; state <= IDLE;
            end
          end else if (dur > 8'd34) begin
            err <= 1'b1; state <= IDLE;
          end
        RPT_MARK:
          if (mark_end) begin
            state <= IDLE;
            if (in_win(dur, 8'd7, 8'd13)) repeat_pulse <= have_frame;
            else err <= 1'b1;
          end else if (dur > 8'd13) begin
            err <= 1'b1; state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= 1'b0;
    else       busy <= (state != IDLE);
  end

endmodule
